// File: rtl/alu_decoder.sv
// RV32I issue-side decoder for the 3-bit ALU: valid/ready in, registered valid/ready out
// with a single skid entry. Optional perf counters are built when ALU_DEC_PERF_EN is defined.
module alu_decoder #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_opcode,
  output logic [XLEN-1:0] out_left,
  output logic [XLEN-1:0] out_right,
  output logic [4:0]      out_rd,
  output logic            out_illegal
`ifdef ALU_DEC_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_issued,
  output logic [CNT_W-1:0] perf_illegal
`endif
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic [2:0]      dec_opcode;
  logic [XLEN-1:0] dec_left;
  logic [XLEN-1:0] dec_right;
  logic            dec_illegal;
  logic [XLEN-1:0] imm;

  logic            out_valid_reg;
  logic [2:0]      out_opcode_reg;
  logic [XLEN-1:0] out_left_reg;
  logic [XLEN-1:0] out_right_reg;
  logic [4:0]      out_rd_reg;
  logic            out_illegal_reg;

  logic            skid_full_reg;
  logic [2:0]      skid_opcode_reg;
  logic [XLEN-1:0] skid_left_reg;
  logic [XLEN-1:0] skid_right_reg;
  logic [4:0]      skid_rd_reg;
  logic            skid_illegal_reg;

  logic in_xfer;
  logic out_xfer;

  assign imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};

  always_comb begin
    dec_opcode  = ALU_ADD;
    dec_left    = '0;
    dec_right   = '0;
    dec_illegal = 1'b1;
    case (in_inst[6:0])
      OP_REG: begin
        if (in_inst[14:12] == 3'b000 && in_inst[31:25] == 7'b0000000) begin
          dec_opcode  = ALU_ADD;
          dec_illegal = 1'b0;
        end else if (in_inst[14:12] == 3'b000 && in_inst[31:25] == 7'b0100000) begin
          dec_opcode  = ALU_SUB;
          dec_illegal = 1'b0;
        end else if (in_inst[14:12] == 3'b111 && in_inst[31:25] == 7'b0000000) begin
          dec_opcode  = ALU_AND;
          dec_illegal = 1'b0;
        end
        if (!dec_illegal) begin
          dec_left  = in_rs1;
          dec_right = in_rs2;
        end
      end
      OP_IMM: begin
        if (in_inst[14:12] == 3'b000) begin
          dec_opcode  = ALU_ADD;
          dec_illegal = 1'b0;
        end else if (in_inst[14:12] == 3'b111) begin
          dec_opcode  = ALU_AND;
          dec_illegal = 1'b0;
        end
        if (!dec_illegal) begin
          dec_left  = in_rs1;
          dec_right = imm;
        end
      end
      default: ;
    endcase
  end

  // in_ready comes straight from a flop, so upstream never sees a combinational path.
  assign in_ready = !skid_full_reg;
  assign in_xfer  = in_valid && !skid_full_reg;
  assign out_xfer = out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      out_opcode_reg   <= '0;
      out_left_reg     <= '0;
      out_right_reg    <= '0;
      out_rd_reg       <= '0;
      out_illegal_reg  <= 1'b0;
      skid_full_reg    <= 1'b0;
      skid_opcode_reg  <= '0;
      skid_left_reg    <= '0;
      skid_right_reg   <= '0;
      skid_rd_reg      <= '0;
      skid_illegal_reg <= 1'b0;
    end else begin
      if (out_xfer || !out_valid_reg) begin
        // Skid is older than anything on the input, so it wins the output slot.
        if (skid_full_reg) begin
          out_valid_reg   <= 1'b1;
          out_opcode_reg  <= skid_opcode_reg;
          out_left_reg    <= skid_left_reg;
          out_right_reg   <= skid_right_reg;
          out_rd_reg      <= skid_rd_reg;
          out_illegal_reg <= skid_illegal_reg;
          skid_full_reg   <= 1'b0;
        end else if (in_xfer) begin
          out_valid_reg   <= 1'b1;
          out_opcode_reg  <= dec_opcode;
          out_left_reg    <= dec_left;
          out_right_reg   <= dec_right;
          out_rd_reg      <= in_inst[11:7];
          out_illegal_reg <= dec_illegal;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_full_reg    <= 1'b1;
        skid_opcode_reg  <= dec_opcode;
        skid_left_reg    <= dec_left;
        skid_right_reg   <= dec_right;
        skid_rd_reg      <= in_inst[11:7];
        skid_illegal_reg <= dec_illegal;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_opcode  = out_opcode_reg;
  assign out_left    = out_left_reg;
  assign out_right   = out_right_reg;
  assign out_rd      = out_rd_reg;
  assign out_illegal = out_illegal_reg;

`ifdef ALU_DEC_PERF_EN
  logic [CNT_W-1:0] perf_issued_reg;
  logic [CNT_W-1:0] perf_illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_reg  <= '0;
      perf_illegal_reg <= '0;
    end else if (out_xfer) begin
      perf_issued_reg <= perf_issued_reg + 1'b1;
      if (out_illegal_reg) perf_illegal_reg <= perf_illegal_reg + 1'b1;
    end
  end

  assign perf_issued  = perf_issued_reg;
  assign perf_illegal = perf_illegal_reg;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: a queue-based occupancy/decode model checked every cycle,
// plus literal expectations for the named scenarios (perf counters when ALU_DEC_PERF_EN is set).
module tb_alu_decoder;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] left;
    logic [31:0] right;
    logic [4:0]  rd;
    logic        illegal;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [31:0] out_left;
  logic [31:0] out_right;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_DEC_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_illegal;
`endif

  alu_decoder #(.XLEN(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
`ifdef ALU_DEC_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_illegal(perf_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level decode: the table of supported encodings, everything else illegal.
  function automatic rec_t model_decode(input logic [31:0] inst, input logic [31:0] rs1,
                                        input logic [31:0] rs2);
    rec_t r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    op  = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    imm = 32'($signed(inst[31:20]));
    r   = '{opcode: 3'b000, left: 32'd0, right: 32'd0, rd: inst[11:7], illegal: 1'b1};
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00)
      r = '{opcode: 3'b000, left: rs1, right: rs2, rd: inst[11:7], illegal: 1'b0};
    else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20)
      r = '{opcode: 3'b100, left: rs1, right: rs2, rd: inst[11:7], illegal: 1'b0};
    else if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00)
      r = '{opcode: 3'b111, left: rs1, right: rs2, rd: inst[11:7], illegal: 1'b0};
    else if (op == 7'h13 && f3 == 3'd0)
      r = '{opcode: 3'b000, left: rs1, right: imm, rd: inst[11:7], illegal: 1'b0};
    else if (op == 7'h13 && f3 == 3'd7)
      r = '{opcode: 3'b111, left: rs1, right: imm, rd: inst[11:7], illegal: 1'b0};
    return r;
  endfunction

  rec_t        model_q[$];
  int          m_issued = 0;
  int          m_illegal = 0;
  int          cyc = 0;
  int          log_n = 0;
  logic [31:0] log_right[0:63];
  logic        log_ill[0:63];
  int          log_cyc[0:63];

  // Compare process: outputs are stable at the falling edge; handshakes seen here
  // are the ones that complete at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_q.delete();
      m_issued  = 0;
      m_illegal = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", out_left | out_right | {27'd0, out_rd} | {29'd0, out_opcode}
                          | {31'd0, out_illegal}, 32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
`ifdef ALU_DEC_PERF_EN
      chk("perf_issued", {16'd0, perf_issued}, 32'(m_issued & 16'hFFFF));
      chk("perf_illegal", {16'd0, perf_illegal}, 32'(m_illegal & 16'hFFFF));
`endif
      if (out_valid && model_q.size() > 0) begin
        chk("out_opcode", {29'd0, out_opcode}, {29'd0, model_q[0].opcode});
        chk("out_left", out_left, model_q[0].left);
        chk("out_right", out_right, model_q[0].right);
        chk("out_rd", {27'd0, out_rd}, {27'd0, model_q[0].rd});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, model_q[0].illegal});
      end
      if (out_valid && out_ready) begin
        if (log_n < 64) begin
          log_right[log_n] = out_right;
          log_ill[log_n]   = out_illegal;
          log_cyc[log_n]   = cyc;
          log_n++;
        end
        m_issued++;
        if (out_illegal) m_illegal++;
        if (model_q.size() > 0) void'(model_q.pop_front());
      end
      if (in_valid && in_ready) model_q.push_back(model_decode(in_inst, in_rs1, in_rs2));
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    logic r;
    int   n;
    in_valid = 1'b1;
    in_inst  = inst;
    in_rs1   = rs1;
    in_rs2   = rs2;
    n = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lit(input string tag, input logic [2:0] op, input logic [31:0] l,
                           input logic [31:0] r, input logic [4:0] rd, input logic ill);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_opcode"}, {29'd0, out_opcode}, {29'd0, op});
    chk({tag, "_left"}, out_left, l);
    chk({tag, "_right"}, out_right, r);
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ill_cnt;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Basic decode with literal expectations.
    send(32'h002081B3, 32'd4, 32'd3); in_valid = 1'b0;
    check_lit("add", 3'b000, 32'd4, 32'd3, 5'd3, 1'b0);
    idle(1);
    send(32'h402081B3, 32'd7, 32'd3); in_valid = 1'b0;
    check_lit("sub", 3'b100, 32'd7, 32'd3, 5'd3, 1'b0);
    idle(1);
    send(32'hFFF0F293, 32'h0000000C, 32'd99); in_valid = 1'b0;
    check_lit("andi", 3'b111, 32'h0000000C, 32'hFFFFFFFF, 5'd5, 1'b0);
    idle(1);
    send(32'h00000000, 32'd5, 32'd6); in_valid = 1'b0;
    check_lit("ill_zero", 3'b000, 32'd0, 32'd0, 5'd0, 1'b1);
    idle(1);
    send(32'h0020C1B3, 32'd5, 32'd6); in_valid = 1'b0;
    check_lit("ill_xor", 3'b000, 32'd0, 32'd0, 5'd3, 1'b1);
    idle(2);

    // Backpressure: ADDI x1,x0,1..4 with the output stalled for three cycles.
    log_n = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send((32'(k) << 20) | 32'h00000093, 32'd0, 32'd0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_held_first", out_right, 32'd1);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_count", 32'(log_n), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_order", log_right[k], 32'(k + 1));

    // Throughput: eight back-to-back ops drain in eight consecutive cycles.
    log_n = 0;
    for (int k = 0; k < 8; k++) send((32'(10 + k) << 20) | 32'h00000093, 32'd0, 32'd0);
    in_valid = 1'b0;
    idle(3);
    chk("tp_count", 32'(log_n), 32'd8);
    chk("tp_span", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
    for (int k = 0; k < 8; k++) chk("tp_data", log_right[k], 32'(10 + k));

    // Reset with both entries occupied.
    out_ready = 1'b0;
    send(32'h002081B3, 32'd1, 32'd2);
    send(32'h402081B3, 32'd3, 32'd4);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_left", out_left, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
`ifdef ALU_DEC_PERF_EN
    chk("perf_after_rst_issued", {16'd0, perf_issued}, 32'd0);
    chk("perf_after_rst_illegal", {16'd0, perf_illegal}, 32'd0);
`endif
    idle(1);
    log_n = 0;
    send(32'h002081B3, 32'd1, 32'd1);
    send(32'h00000000, 32'd1, 32'd1);
    send(32'h402081B3, 32'd9, 32'd2);
    send(32'h0020C1B3, 32'd1, 32'd1);
    send(32'hFFF0F293, 32'd1, 32'd1);
    in_valid = 1'b0;
    idle(3);
    ill_cnt = 0;
    for (int k = 0; k < log_n; k++) if (log_ill[k]) ill_cnt++;
    chk("post_rst_count", 32'(log_n), 32'd5);
    chk("post_rst_illegal", 32'(ill_cnt), 32'd2);
`ifdef ALU_DEC_PERF_EN
    @(negedge clk);
    chk("perf_issued_5", {16'd0, perf_issued}, 32'd5);
    chk("perf_illegal_2", {16'd0, perf_illegal}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
